// File: rtl/iob_eth_tx_arb.sv
// Transmit arbiter: round-robin ownership of a shared Ethernet TX buffer, send handshake
// with the transmitter, acknowledge timeout and inter-frame gap enforcement.
module iob_eth_tx_arb #(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned IFG_CYCLES  = 24,
    parameter int unsigned ACK_TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    commit,
    input  logic [NREQ*11-1:0] req_nbytes,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               err,
    output logic               busy,
    output logic               tx_send,
    output logic [10:0]        tx_nbytes,
    input  logic               tx_ready
);

    localparam int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CMAX = (IFG_CYCLES > ACK_TIMEOUT) ? IFG_CYCLES : ACK_TIMEOUT;
    localparam int unsigned CW   = $clog2(CMAX + 1);
    localparam logic [10:0] MAX_BYTES = 11'd1500;

    typedef enum logic [2:0] {StIdle, StGrant, StSend, StWaitDone, StGap} state_e;

    state_e        state_q;
    logic [IW-1:0] owner_q;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] pick;
    logic [IW-1:0] next_ptr;
    logic [CW-1:0] cnt_q;
    logic          rdy_meta_q;
    logic          rdy_sync_q;
    logic          own_req;
    logic          own_commit;
    logic [10:0]   own_nb;

    // Reset high so a ready transmitter is not mistaken for an acknowledge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_meta_q <= 1'b1;
            rdy_sync_q <= 1'b1;
        end else begin
            rdy_meta_q <= tx_ready;
            rdy_sync_q <= rdy_meta_q;
        end
    end

    // Lowest set request at or above rr_ptr, else lowest set request overall.
    always_comb begin
        pick = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[j]) pick = IW'(j);
        end
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (req[j] && (IW'(j) >= rr_ptr_q)) pick = IW'(j);
        end
    end

    always_comb begin
        own_nb = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) own_nb = req_nbytes[i*11 +: 11];
        end
    end

    assign own_req    = |(req & gnt);
    assign own_commit = |(commit & gnt);
    assign next_ptr   = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
    assign busy       = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            tx_send   <= 1'b0;
            tx_nbytes <= '0;
            owner_q   <= '0;
            rr_ptr_q  <= '0;
            cnt_q     <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state_q)
                StIdle: begin
                    gnt <= '0;
                    if (|req) begin
                        owner_q <= pick;
                        gnt     <= NREQ'(1) << pick;
                        state_q <= StGrant;
                    end
                end
                StGrant: begin
                    if (!own_req) begin
                        gnt      <= '0;
                        rr_ptr_q <= next_ptr;
                        state_q  <= StIdle;
                    end else if (own_commit) begin
                        tx_nbytes <= own_nb;
                        if ((own_nb == '0) || (own_nb > MAX_BYTES)) begin
                            done     <= gnt;
                            err      <= 1'b1;
                            rr_ptr_q <= next_ptr;
                            state_q  <= StIdle;
                        end else begin
                            tx_send <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= StSend;
                        end
                    end
                end
                StSend: begin
                    if (!rdy_sync_q) begin
                        tx_send <= 1'b0;
                        state_q <= StWaitDone;
                    end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                        tx_send  <= 1'b0;
                        done     <= gnt;
                        err      <= 1'b1;
                        rr_ptr_q <= next_ptr;
                        state_q  <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (rdy_sync_q) begin
                        cnt_q   <= CW'(IFG_CYCLES - 1);
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    // gnt is left set so it drops together with the done pulse
                    if (cnt_q == '0) begin
                        done     <= gnt;
                        rr_ptr_q <= next_ptr;
                        state_q  <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_iob_eth_tx_arb.sv
// Directed bench for iob_eth_tx_arb: scoreboard of expected done/err pulses plus handshake
// timing, round-robin order, length rejects, timeout, abort and mid-frame reset.
module tb_iob_eth_tx_arb;

    localparam int NREQ = 2;
    localparam int IFG  = 24;
    localparam int ACK  = 64;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    commit;
    logic [NREQ*11-1:0] req_nbytes;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic               err;
    logic               busy;
    logic               tx_send;
    logic [10:0]        tx_nbytes;
    logic               tx_ready;

    typedef struct packed {
        logic [NREQ-1:0] vec;
        logic            err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks     = 0;
    int   errors     = 0;
    int   send_rises = 0;
    logic send_prev  = 1'b0;

    iob_eth_tx_arb #(
        .NREQ        (NREQ),
        .IFG_CYCLES  (IFG),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .commit     (commit),
        .req_nbytes (req_nbytes),
        .gnt        (gnt),
        .done       (done),
        .err        (err),
        .busy       (busy),
        .tx_send    (tx_send),
        .tx_nbytes  (tx_nbytes),
        .tx_ready   (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
            if (tx_send === 1'b1 && send_prev !== 1'b1) send_rises++;
            if (done !== '0) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_vec", 32'(done), 32'(mon_e.vec));
                    chk("done_err", 32'(err), 32'(mon_e.err));
                    chk("gnt_at_done", 32'(gnt), 32'(mon_e.vec));
                end
            end else begin
                chk("err_without_done", 32'(err), 32'd0);
            end
        end
        send_prev = tx_send;
    end

    // Owner idx already holds gnt; commits, acks 3 cycles in, releases after low_cycles.
    task automatic run_frame(input int idx, input logic [10:0] nb, input int low_cycles,
                             input string tag);
        exp_t e;
        int   n;
        req_nbytes[idx*11 +: 11] = nb;
        commit[idx] = 1'b1;
        e.vec = NREQ'(1) << idx;
        e.err = 1'b0;
        sb.push_back(e);
        tick();
        commit = '0;
        chk({tag, "_send"}, 32'(tx_send), 32'd1);
        chk({tag, "_nbytes"}, 32'(tx_nbytes), 32'(nb));
        repeat (2) tick();
        tx_ready = 1'b0;
        n = 0;
        while (tx_send === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        // two synchronizer stages plus the state update
        chk({tag, "_send_drop"}, n, 32'd3);
        repeat (low_cycles) tick();
        chk({tag, "_wait_busy"}, 32'({tx_send, busy}), 32'd1);
        tx_ready = 1'b1;
        n = 0;
        while (done === '0 && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_ifg"}, n, IFG + 3);
        chk({tag, "_hold_nbytes"}, 32'(tx_nbytes), 32'(nb));
    endtask

    initial begin
        int   n;
        int   exp_idx;
        exp_t e;

        rst_n      = 1'b0;
        req        = '0;
        commit     = '0;
        req_nbytes = '0;
        tx_ready   = 1'b1;
        repeat (3) tick();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done_err", 32'({done, err}), 32'd0);
        chk("rst_busy_send", 32'({busy, tx_send}), 32'd0);
        chk("rst_nbytes", 32'(tx_nbytes), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_gnt", 32'(gnt), 32'd0);

        // Single frame on requester 0
        req = 2'b01;
        tick();
        chk("t1_gnt", 32'(gnt), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        run_frame(0, 11'd64, 94, "t1");
        req = '0;
        tick();
        chk("t1_release", 32'({gnt, busy}), 32'd0);
        chk("t1_sends", send_rises, 32'd1);

        // Both requesting; pointer sits at 1 after the first frame
        req = 2'b11;
        tick();
        for (int k = 0; k < 4; k++) begin
            exp_idx = (k % 2 == 0) ? 1 : 0;
            chk("rr_gnt", 32'(gnt), 32'(1 << exp_idx));
            run_frame(exp_idx, (exp_idx == 1) ? 11'd200 : 11'd100, 10, "rr");
            tick();
        end
        chk("rr_next", 32'(gnt), 32'd2);
        req = '0;
        tick();
        chk("rr_drop", 32'({gnt, busy}), 32'd0);
        chk("rr_sends", send_rises, 32'd5);

        // Length rejects: 0 and 1501 bytes
        e.vec = 2'b01;
        e.err = 1'b1;
        req = 2'b01;
        req_nbytes[10:0] = 11'd0;
        tick();
        chk("rej0_gnt", 32'(gnt), 32'd1);
        sb.push_back(e);
        commit = 2'b01;
        tick();
        commit = '0;
        chk("rej0_done", 32'({done, err}), 32'd3);
        chk("rej0_send", 32'(tx_send), 32'd0);
        req_nbytes[10:0] = 11'd1501;
        tick();
        chk("rej1_gnt", 32'(gnt), 32'd1);
        sb.push_back(e);
        commit = 2'b01;
        tick();
        commit = '0;
        chk("rej1_done", 32'({done, err}), 32'd3);
        chk("rej1_send", 32'(tx_send), 32'd0);
        req = '0;
        tick();
        chk("rej_idle", 32'({gnt, busy}), 32'd0);
        chk("rej_sends", send_rises, 32'd5);

        // Abort: requester 1 withdraws before commit, pointer moves on to 0
        req = 2'b10;
        tick();
        chk("ab_gnt", 32'(gnt), 32'd2);
        req = '0;
        tick();
        chk("ab_clear", 32'({gnt, busy}), 32'd0);
        req = 2'b11;
        tick();
        chk("ab_next", 32'(gnt), 32'd1);

        // Timeout with a 1500-byte frame: transmitter never acknowledges
        req = 2'b01;
        req_nbytes[10:0] = 11'd1500;
        e.vec = 2'b01;
        e.err = 1'b1;
        sb.push_back(e);
        commit = 2'b01;
        tick();
        commit = '0;
        chk("to_nbytes", 32'(tx_nbytes), 32'd1500);
        n = 0;
        while (tx_send === 1'b1 && n < 200) begin
            n++;
            tick();
        end
        chk("to_len", n, ACK);
        chk("to_done", 32'({done, err}), 32'd3);
        req = '0;
        tick();
        chk("to_idle", 32'({gnt, busy, tx_send}), 32'd0);

        // Reset while waiting for the transmitter to finish
        req = 2'b10;
        req_nbytes[21:11] = 11'd300;
        tick();
        chk("rs_gnt", 32'(gnt), 32'd2);
        e.vec = 2'b10;
        e.err = 1'b0;
        sb.push_back(e);
        commit = 2'b10;
        tick();
        commit = '0;
        repeat (2) tick();
        tx_ready = 1'b0;
        n = 0;
        while (tx_send === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("rs_send_drop", n, 32'd3);
        repeat (5) tick();
        rst_n = 1'b0;
        req   = '0;
        sb.delete();
        tick();
        chk("rs_outputs", 32'({gnt, done, err, busy, tx_send}), 32'd0);
        chk("rs_nbytes", 32'(tx_nbytes), 32'd0);
        tx_ready = 1'b1;
        rst_n    = 1'b1;
        repeat (30) tick();
        chk("rs_quiet", 32'({gnt, busy}), 32'd0);
        req = 2'b01;
        tick();
        chk("rs_regnt", 32'(gnt), 32'd1);
        run_frame(0, 11'd64, 20, "rs");
        req = '0;
        tick();
        chk("rs_idle", 32'({gnt, busy}), 32'd0);

        chk("sends_total", send_rises, 32'd8);
        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
